// File: rtl/ram_scan_reader.sv
// Read-side scan sequencer for the switch-filled RAM: walks base..last (with wrap) and streams words out.
// Optional running checksum on `sum` is built only when RAM_SCAN_SUM_EN is defined; otherwise `sum` is 0.
module ram_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        last_addr,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        ram_address,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  localparam int SUM_W = DATA_W + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] last_q;
  logic              load;
  logic              capture;
  logic              advance;

  assign ram_wren = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy       = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // wait_cnt counts cycles already spent in WAIT; the last one captures q
        if (wait_cnt == 2'(RD_LAT - 1)) begin
          capture    = 1'b1;
          next_state = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (ram_address == last_q) begin
            next_state = S_DONE;
          end else begin
            advance    = 1'b1;
            next_state = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      ram_address <= '0;
      last_q      <= '0;
      out_data    <= '0;
      out_addr    <= '0;
    end else begin
      if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;
      else                 wait_cnt <= '0;
      if (load) begin
        ram_address <= base_addr;
        last_q      <= last_addr;
      end else if (advance) begin
        ram_address <= ram_address + ADDR_W'(1);
      end
      if (capture) begin
        out_data <= ram_q;
        out_addr <= ram_address;
      end
    end
  end

`ifdef RAM_SCAN_SUM_EN
  logic [SUM_W-1:0] sum_q;

  // Cleared on start acceptance, then holds past DONE until the next scan
  always_ff @(posedge clock) begin
    if (reset)        sum_q <= '0;
    else if (load)    sum_q <= '0;
    else if (capture) sum_q <= sum_q + SUM_W'(ram_q);
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomized bench for ram_scan_reader: RD_LAT=1 and RD_LAT=2 instances against a queue-based scan model.
module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int SW = AW + DW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, sel, out_ready;
  logic [AW-1:0] base_addr, last_addr;
  logic          start1, start2;

  logic          busy1, done1, wren1, valid1;
  logic [AW-1:0] ram_addr1, out_addr1;
  logic [DW-1:0] q1, out_data1;
  logic [SW-1:0] sum1;

  logic          busy2, done2, wren2, valid2;
  logic [AW-1:0] ram_addr2, out_addr2;
  logic [DW-1:0] q2, out_data2;
  logic [SW-1:0] sum2;

  logic [DW-1:0] mem [0:31];

  int total = 0;
  int bad   = 0;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  // RD_LAT=1 RAM: unregistered q; RD_LAT=2 RAM: registered q
  assign q1 = mem[ram_addr1];
  always @(posedge clock) q2 <= mem[ram_addr2];

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .base_addr(base_addr), .last_addr(last_addr),
    .busy(busy1), .done(done1), .ram_address(ram_addr1), .ram_wren(wren1),
    .ram_q(q1), .out_valid(valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_addr(out_addr1), .sum(sum1)
  );

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .base_addr(base_addr), .last_addr(last_addr),
    .busy(busy2), .done(done2), .ram_address(ram_addr2), .ram_wren(wren2),
    .ram_q(q2), .out_valid(valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_addr(out_addr2), .sum(sum2)
  );

  logic          o_busy, o_done, o_valid, o_wren;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic [SW-1:0] o_sum;

  assign o_busy  = sel ? busy2     : busy1;
  assign o_done  = sel ? done2     : done1;
  assign o_valid = sel ? valid2    : valid1;
  assign o_wren  = sel ? wren2     : wren1;
  assign o_data  = sel ? out_data2 : out_data1;
  assign o_addr  = sel ? out_addr2 : out_addr1;
  assign o_sum   = sel ? sum2      : sum1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: random ready; mode 2: 5-cycle stall on the 2nd word
  task automatic applyStimulus(input int lat, input int b, input int l, input int mode, input bit inject);
    int exp_addr[$];
    int exp_data[$];
    int exp_sum, es, a, n, cycles, stalls, busy_cnt, got, stall_left;
    bit first_valid, prev_stall, done_seen, stalled_once, r;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;

    exp_sum = 0;
    a = b;
    while (1) begin
      exp_addr.push_back(a);
      exp_data.push_back(int'(mem[a]));
      exp_sum += int'(mem[a]);
      if (a == l) break;
      a = (a + 1) % 32;
    end
    n = exp_addr.size();
`ifdef RAM_SCAN_SUM_EN
    es = exp_sum;
`else
    es = 0;
`endif

    @(negedge clock);
    sel       = (lat == 2);
    base_addr = AW'(b);
    last_addr = AW'(l);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start      = 1'b0;
    base_addr  = AW'($urandom);
    last_addr  = AW'($urandom);
    cycles     = 1;
    stalls     = 0;
    busy_cnt   = 0;
    got        = 0;
    stall_left = 0;
    first_valid  = 0;
    prev_stall   = 0;
    done_seen    = 0;
    stalled_once = 0;
    pd = '0;
    pa = '0;

    while (!done_seen && cycles < 2000) begin
      if (o_done) begin
        done_seen = 1;
      end else begin
        if (o_busy) busy_cnt++;
        if (o_valid) begin
          if (!first_valid) begin
            first_valid = 1;
            checkOutput("first_valid_lat", cycles, lat + 2);
          end
          if (prev_stall) begin
            checkOutput("hold_data", o_data, pd);
            checkOutput("hold_addr", o_addr, pa);
          end
          case (mode)
            1: r = ($urandom_range(0, 2) != 0);
            2: begin
              if (got == 1 && !stalled_once) begin
                stall_left   = 5;
                stalled_once = 1;
              end
              r = (stall_left == 0);
              if (stall_left > 0) stall_left--;
            end
            default: r = 1;
          endcase
          out_ready = r;
          if (r) begin
            if (got < n) begin
              checkOutput("word_addr", o_addr, exp_addr[got]);
              checkOutput("word_data", o_data, exp_data[got]);
            end else begin
              checkOutput("extra_word", got, n);
            end
            got++;
            prev_stall = 0;
          end else begin
            stalls++;
            prev_stall = 1;
            pd = o_data;
            pa = o_addr;
          end
        end else begin
          out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start = (inject && cycles == lat + 3);
        @(posedge clock);
        @(negedge clock);
        cycles++;
      end
    end

    start = 1'b0;
    if (!done_seen) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      checkOutput("word_count", got, n);
      checkOutput("done_lat", cycles, n * (lat + 2) + 1 + stalls);
      checkOutput("busy_cycles", busy_cnt, n * (lat + 2) + stalls);
      checkOutput("done_busy_low", o_busy, 0);
      checkOutput("done_valid_low", o_valid, 0);
      checkOutput("sum", o_sum, es);
      checkOutput("wren", o_wren, 0);
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checkOutput("done_one_cycle", o_done, 0);
      checkOutput("idle_busy", o_busy, 0);
      checkOutput("idle_valid", o_valid, 0);
      checkOutput("sum_hold", o_sum, es);
    end
  endtask

  task automatic resetMidScan();
    int got, cycles, done_cnt;
    bit hit;
    @(negedge clock);
    sel       = 1'b0;
    base_addr = '0;
    last_addr = 5'd31;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start  = 1'b0;
    got    = 0;
    cycles = 0;
    hit    = 0;
    while (!hit && cycles < 100) begin
      if (valid1) begin
        if (got == 2) begin
          reset = 1'b1;
          hit   = 1;
        end
        got++;
      end
      @(posedge clock);
      @(negedge clock);
      cycles++;
    end
    checkOutput("reset_reached_3rd", hit, 1);
    reset = 1'b0;
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_valid", valid1, 0);
    checkOutput("rst_ram_addr", ram_addr1, 0);
    checkOutput("rst_done", done1, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done1) done_cnt++;
    end
    checkOutput("rst_no_done", done_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DW'(i % 16);
    reset     = 1'b1;
    start     = 1'b0;
    sel       = 1'b0;
    base_addr = '0;
    last_addr = '0;
    out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("reset_busy", busy1, 0);
    checkOutput("reset_done", done1, 0);
    checkOutput("reset_valid", valid1, 0);
    checkOutput("reset_data", out_data1, 0);
    checkOutput("reset_addr", out_addr1, 0);
    checkOutput("reset_ram_addr", ram_addr1, 0);
    checkOutput("reset_wren", wren1, 0);
    checkOutput("reset_sum", sum1, 0);
    checkOutput("reset_valid2", valid2, 0);
    checkOutput("reset_ram_addr2", ram_addr2, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] full-depth scan");
    applyStimulus(1, 0, 31, 0, 0);
    $display("[TB] wrap-around scan");
    applyStimulus(1, 30, 1, 0, 0);
    $display("[TB] single-word scan");
    mem[7] = 4'd9;
    applyStimulus(1, 7, 7, 0, 0);
    $display("[TB] stalled scan");
    applyStimulus(1, 2, 9, 2, 0);
    $display("[TB] reset mid-scan");
    resetMidScan();
    applyStimulus(1, 5, 12, 0, 0);
    $display("[TB] RD_LAT=2 scan with ignored start");
    applyStimulus(2, 0, 3, 0, 1);

    $display("[TB] randomized scans");
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      applyStimulus($urandom_range(1, 2), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
